// File: rtl/oam_dma_ctrl.sv
// OAM DMA controller and memory-bus arbiter: copies 160 bytes from page XX00 to OAM at 0xFE00.
// Optional build macro OAM_DMA_ECHO_REMAP_EN folds source pages 0xE0-0xFF onto work RAM 0xC0-0xDF.
module oam_dma_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        reg_wr,
    input  logic [7:0]  reg_wdata,
    output logic [7:0]  reg_rdata,
    input  logic        cpu_bus_req,
    output logic        cpu_bus_gnt,
    output logic        dma_owns_bus,
    output logic        dma_busy,
    output logic        dma_done,
    output logic [15:0] mem_addr,
    output logic        mem_cs,
    output logic        mem_oe,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        RD_A,
        RD_B,
        WR_A,
        WR_B
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] src_page;
    logic [7:0] idx;
    logic [7:0] data_lat;
    logic       restart_pend;
    logic [7:0] pend_page;
    logic       last_byte;
    logic       restart_now;

    function automatic logic [7:0] map_page(input logic [7:0] page);
`ifdef OAM_DMA_ECHO_REMAP_EN
        map_page = (page >= 8'hE0) ? (page - 8'h20) : page;
`else
        map_page = page;
`endif
    endfunction

    assign last_byte   = (idx == 8'd159);
    // A write landing on the WR_B edge itself restarts just like one that was already pending.
    assign restart_now = (state == WR_B) && (restart_pend || reg_wr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (reg_wr) state_next = START;
            START: if (!cpu_bus_req && !reg_wr) state_next = RD_A;
            RD_A:  state_next = RD_B;
            RD_B:  state_next = WR_A;
            WR_A:  state_next = WR_B;
            WR_B:  state_next = (restart_now || !last_byte) ? RD_A : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_page     <= 8'h00;
            idx          <= 8'd0;
            data_lat     <= 8'h00;
            restart_pend <= 1'b0;
            pend_page    <= 8'h00;
            reg_rdata    <= 8'hFF;
            dma_done     <= 1'b0;
        end else begin
            dma_done <= 1'b0;
            if (reg_wr) begin
                reg_rdata <= reg_wdata;
            end
            case (state)
                IDLE: begin
                    if (reg_wr) begin
                        src_page <= map_page(reg_wdata);
                        idx      <= 8'd0;
                    end
                end
                START: begin
                    if (reg_wr) begin
                        src_page <= map_page(reg_wdata);
                    end
                end
                RD_A, WR_A: begin
                    if (reg_wr) begin
                        pend_page    <= map_page(reg_wdata);
                        restart_pend <= 1'b1;
                    end
                end
                RD_B: begin
                    data_lat <= mem_rdata;
                    if (reg_wr) begin
                        pend_page    <= map_page(reg_wdata);
                        restart_pend <= 1'b1;
                    end
                end
                WR_B: begin
                    if (restart_now) begin
                        src_page     <= reg_wr ? map_page(reg_wdata) : pend_page;
                        idx          <= 8'd0;
                        restart_pend <= 1'b0;
                    end else if (last_byte) begin
                        dma_done <= 1'b1;
                    end else begin
                        idx <= idx + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Strobes are decoded from state so an async reset drops them without waiting for a clock.
    always_comb begin
        dma_owns_bus = 1'b0;
        dma_busy     = (state != IDLE);
        mem_addr     = 16'h0000;
        mem_cs       = 1'b0;
        mem_oe       = 1'b0;
        mem_we       = 1'b0;
        mem_wdata    = 8'h00;
        case (state)
            RD_A, RD_B: begin
                dma_owns_bus = 1'b1;
                mem_addr     = {src_page, idx};
                mem_cs       = 1'b1;
                mem_oe       = 1'b1;
            end
            WR_A, WR_B: begin
                dma_owns_bus = 1'b1;
                mem_addr     = {8'hFE, idx};
                mem_wdata    = data_lat;
                mem_cs       = 1'b1;
                mem_we       = (state == WR_B);
            end
            default: ;
        endcase
    end

    assign cpu_bus_gnt = cpu_bus_req & ~dma_owns_bus;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Scoreboard bench for oam_dma_ctrl: expected OAM writes and done pulses are queued, a monitor checks them.
// Compile with OAM_DMA_ECHO_REMAP_EN defined to check the echo-remapped build.
module tb_oam_dma_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        reg_wr;
    logic [7:0]  reg_wdata;
    logic [7:0]  reg_rdata;
    logic        cpu_bus_req;
    logic        cpu_bus_gnt;
    logic        dma_owns_bus;
    logic        dma_busy;
    logic        dma_done;
    logic [15:0] mem_addr;
    logic        mem_cs;
    logic        mem_oe;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          is_done;
        logic [15:0] addr;
        logic [7:0]  data;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    oam_dma_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .reg_wr       (reg_wr),
        .reg_wdata    (reg_wdata),
        .reg_rdata    (reg_rdata),
        .cpu_bus_req  (cpu_bus_req),
        .cpu_bus_gnt  (cpu_bus_gnt),
        .dma_owns_bus (dma_owns_bus),
        .dma_busy     (dma_busy),
        .dma_done     (dma_done),
        .mem_addr     (mem_addr),
        .mem_cs       (mem_cs),
        .mem_oe       (mem_oe),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    // Memory contents depend on both page and offset so a wrong source page shows up as wrong data.
    function automatic logic [7:0] mem_val(input logic [15:0] a);
        return a[7:0] ^ 8'h5A ^ (a[15:8] - 8'hC0);
    endfunction

    assign mem_rdata = (mem_cs && mem_oe) ? mem_val(mem_addr) : 8'h00;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_copy(input logic [7:0] page, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            logic [7:0] ib;
            ib = 8'(i);
            sb_q.push_back('{is_done: 1'b0, addr: {8'hFE, ib}, data: mem_val({page, ib})});
        end
    endtask

    task automatic push_done();
        sb_q.push_back('{is_done: 1'b1, addr: 16'h0000, data: 8'h00});
    endtask

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (sb_q.size() == 0) begin
                checkOutput("write with empty scoreboard", 32'(sb_q.size()), 32'd1);
            end else begin
                mon_e = sb_q.pop_front();
                checkOutput("write kind", 32'(mon_e.is_done), 32'd0);
                checkOutput("write addr", 32'(mem_addr), 32'(mon_e.addr));
                checkOutput("write data", 32'(mem_wdata), 32'(mon_e.data));
                checkOutput("write cs", 32'(mem_cs), 32'd1);
                checkOutput("write oe", 32'(mem_oe), 32'd0);
            end
        end
        if (dma_done === 1'b1) begin
            if (sb_q.size() == 0) begin
                checkOutput("done with empty scoreboard", 32'(sb_q.size()), 32'd1);
            end else begin
                mon_e = sb_q.pop_front();
                checkOutput("done kind", 32'(mon_e.is_done), 32'd1);
            end
        end
    end

    // Triggers a copy of page, optionally stalled and with up to two mid-transfer register writes,
    // and checks busy/owns/gnt/done against the expected cycle numbers (cycle 1 = first START cycle).
    task automatic applyStimulus(input logic [7:0] page, input int stall, input int done_cyc,
                                 input int wr_cyc_a, input logic [7:0] page_a,
                                 input int wr_cyc_b, input logic [7:0] page_b,
                                 input int stop_cyc);
        logic own_exp;
        reg_wr      = 1'b1;
        reg_wdata   = page;
        cpu_bus_req = (stall > 0);
        @(posedge clk);
        #1;
        reg_wr = 1'b0;
        for (int c = 1; c <= stop_cyc; c++) begin
            @(negedge clk);
            own_exp = (c >= stall + 2) && (c < done_cyc);
            checkOutput("busy", 32'(dma_busy), 32'(c < done_cyc));
            checkOutput("owns bus", 32'(dma_owns_bus), 32'(own_exp));
            checkOutput("cpu grant", 32'(cpu_bus_gnt), 32'(cpu_bus_req && !own_exp));
            checkOutput("done pulse", 32'(dma_done), 32'(c == done_cyc));
            @(posedge clk);
            #1;
            reg_wr      = (c + 1 == wr_cyc_a) || (c + 1 == wr_cyc_b);
            reg_wdata   = (c + 1 == wr_cyc_b) ? page_b : page_a;
            cpu_bus_req = (c + 1 <= stall) || ((c + 1) % 7 == 3);
        end
        reg_wr      = 1'b0;
        cpu_bus_req = 1'b0;
    endtask

    task automatic check_reset_outputs();
        checkOutput("reset rdata", 32'(reg_rdata), 32'h0000_00FF);
        checkOutput("reset owns", 32'(dma_owns_bus), 32'd0);
        checkOutput("reset busy", 32'(dma_busy), 32'd0);
        checkOutput("reset done", 32'(dma_done), 32'd0);
        checkOutput("reset addr", 32'(mem_addr), 32'd0);
        checkOutput("reset cs", 32'(mem_cs), 32'd0);
        checkOutput("reset oe", 32'(mem_oe), 32'd0);
        checkOutput("reset we", 32'(mem_we), 32'd0);
        checkOutput("reset wdata", 32'(mem_wdata), 32'd0);
    endtask

    initial begin
        logic [7:0] echo_page;
        rst         = 1'b1;
        reg_wr      = 1'b0;
        reg_wdata   = 8'h00;
        cpu_bus_req = 1'b0;
        #2;
        check_reset_outputs();
        cpu_bus_req = 1'b1;
        #1;
        checkOutput("idle grant", 32'(cpu_bus_gnt), 32'd1);
        cpu_bus_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] basic copy");
        push_copy(8'hC0, 0, 159);
        push_done();
        applyStimulus(8'hC0, 0, 642, 0, 8'h00, 0, 8'h00, 642);
        checkOutput("basic rdata", 32'(reg_rdata), 32'h0000_00C0);
        checkOutput("basic drained", 32'(sb_q.size()), 32'd0);
        checkOutput("idle addr", 32'(mem_addr), 32'd0);

        $display("[TB] contention");
        push_copy(8'hC1, 0, 159);
        push_done();
        applyStimulus(8'hC1, 5, 647, 0, 8'h00, 0, 8'h00, 647);
        checkOutput("contention drained", 32'(sb_q.size()), 32'd0);

        $display("[TB] restart");
        push_copy(8'hC0, 0, 50);
        push_copy(8'hC2, 0, 159);
        push_done();
        applyStimulus(8'hC0, 0, 846, 202, 8'hC1, 203, 8'hC2, 846);
        checkOutput("restart rdata", 32'(reg_rdata), 32'h0000_00C2);
        checkOutput("restart drained", 32'(sb_q.size()), 32'd0);

        $display("[TB] boundary restart");
        push_copy(8'hC0, 0, 159);
        push_copy(8'hC1, 0, 159);
        push_done();
        applyStimulus(8'hC0, 0, 1282, 641, 8'hC1, 0, 8'h00, 1282);
        checkOutput("boundary drained", 32'(sb_q.size()), 32'd0);

        $display("[TB] async reset at byte 80");
        push_copy(8'hC0, 0, 79);
        applyStimulus(8'hC0, 0, 642, 0, 8'h00, 0, 8'h00, 322);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs();
        checkOutput("reset drained", 32'(sb_q.size()), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        push_copy(8'hC4, 0, 159);
        push_done();
        applyStimulus(8'hC4, 0, 642, 0, 8'h00, 0, 8'h00, 642);
        checkOutput("post-reset drained", 32'(sb_q.size()), 32'd0);

        $display("[TB] echo page");
`ifdef OAM_DMA_ECHO_REMAP_EN
        echo_page = 8'hC3;
`else
        echo_page = 8'hE3;
`endif
        push_copy(echo_page, 0, 159);
        push_done();
        applyStimulus(8'hE3, 0, 642, 0, 8'h00, 0, 8'h00, 642);
        checkOutput("echo rdata", 32'(reg_rdata), 32'h0000_00E3);
        checkOutput("echo drained", 32'(sb_q.size()), 32'd0);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
